hex5_press_counter: RTL and testbench

- Upstream stage for the HEX5 decoder. Produces the 4-bit counter state (0000 to 1010) that the decoder displays.
- Takes a raw active-low pushbutton and a direction switch, and advances the count by exactly one per debounced press.
- Wraps at 10 going up and at 0 going down.
- All registers are in a single clock domain.

---
 rtl/hex5_press_counter.sv | 185 ++++++++++++++++++
 tb/tb_hex5_press_counter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex5_press_counter.sv
// hex5_press_counter: debounced pushbutton stepper feeding the HEX5 decoder.
// Synchronizes a raw active-low key and a direction switch, debounces the key,
// and steps a 0..10 counter once per debounced press (wrapping both ways).
//
// Optional build macro: HOLD_REPEAT_EN adds hold-to-repeat stepping
// (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles).
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   asynchronous active-high reset
//   key_n   in   raw pushbutton, low = pressed (asynchronous, bouncy)
//   dir_up  in   raw direction switch, 1 = up, 0 = down (asynchronous)
//   count   out  counter state 0..10
//   wrap    out  one-cycle pulse on a wrapping step
//   pressed out  debounced key level, 1 = held
module hex5_press_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_n,
    input  logic       dir_up,
    output logic [3:0] count,
    output logic       wrap,
    output logic       pressed
);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'd10;

    // Elaboration-time parameter sanity
    if (DEBOUNCE_CYCLES < 1 || CNT_W < 1 ||
        ((CNT_W < 32) && ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)))) begin : g_bad_debounce_cfg
        $error("hex5_press_counter: need DEBOUNCE_CYCLES >= 1 and 2**CNT_W > DEBOUNCE_CYCLES");
    end

    logic             key_meta_q, key_s_q;
    logic             dir_meta_q, dir_s_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             db_fall, db_rise;

`ifdef HOLD_REPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX > 2) ? $clog2(RPT_MAX) : 1;

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat_cfg
        $error("hex5_press_counter: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_on_q, rpt_on_d;   // 1 once the first repeat has fired
`endif

    // Two-flop synchronizers; reset to the idle levels of key and switch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_q <= 1'b1;
            key_s_q    <= 1'b1;
            dir_meta_q <= 1'b1;
            dir_s_q    <= 1'b1;
        end else begin
            key_meta_q <= key_n;
            key_s_q    <= key_meta_q;
            dir_meta_q <= dir_up;
            dir_s_q    <= dir_meta_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_q     <= 1'b1;
            db_cnt_q <= '0;
            state_q  <= RELEASED;
            count_q  <= '0;
            wrap_q   <= 1'b0;
`ifdef HOLD_REPEAT_EN
            rpt_cnt_q <= '0;
            rpt_on_q  <= 1'b0;
`endif
        end else begin
            db_q     <= db_d;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            count_q  <= count_d;
            wrap_q   <= wrap_d;
`ifdef HOLD_REPEAT_EN
            rpt_cnt_q <= rpt_cnt_d;
            rpt_on_q  <= rpt_on_d;
`endif
        end
    end

    // Debounce, FSM next state, step generation and count update
    always_comb begin
        db_d     = db_q;
        db_cnt_d = '0;
        state_d  = state_q;
        count_d  = count_q;
        wrap_d   = 1'b0;
        step     = 1'b0;
`ifdef HOLD_REPEAT_EN
        rpt_cnt_d = '0;
        rpt_on_d  = 1'b0;
`endif

        // Flip on the edge where the run of differing samples hits the limit,
        // so the FSM reacts on that same edge.
        if (key_s_q != db_q) begin
            if (db_cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = key_s_q;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
        db_fall = db_q & ~db_d;
        db_rise = ~db_q & db_d;

        case (state_q)
            RELEASED: begin
                if (db_fall) begin
                    state_d = PRESSED;
                    step    = 1'b1;
                end
            end
            PRESSED: begin
                if (db_rise) begin
                    state_d = RELEASED;
                end
`ifdef HOLD_REPEAT_EN
                else begin
                    rpt_on_d = rpt_on_q;
                    if (rpt_cnt_q == (rpt_on_q ? RPT_W'(REPEAT_PERIOD - 1)
                                               : RPT_W'(REPEAT_DELAY - 1))) begin
                        step     = 1'b1;
                        rpt_on_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
                    end
                end
`endif
            end
            default: state_d = RELEASED;
        endcase

        // Upset values 11..15 recover to 0 regardless of direction
        if (step) begin
            if (count_q > CNT_MAX) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else if (dir_s_q) begin
                if (count_q == CNT_MAX) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                if (count_q == 4'd0) begin
                    count_d = CNT_MAX;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end
    end

    assign count   = count_q;
    assign wrap    = wrap_q;
    assign pressed = (state_q == PRESSED);

endmodule

// File: tb/tb_hex5_press_counter.sv
// Directed bench for hex5_press_counter with a 4-cycle debounce.
module tb_hex5_press_counter;

`ifdef HOLD_REPEAT_EN
    localparam bit RPT = 1'b1;
`else
    localparam bit RPT = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       key_n;
    logic       dir_up;
    logic [3:0] count;
    logic       wrap;
    logic       pressed;

    int errors = 0;
    int checks = 0;

    hex5_press_counter #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .key_n  (key_n),
        .dir_up (dir_up),
        .count  (count),
        .wrap   (wrap),
        .pressed(pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        key_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One clean press: observe count/wrap on the step edge and wrap one edge later
    task automatic press(output logic [3:0] c_step, output logic w_step, output logic w_next);
        key_n = 1'b0;
        repeat (6) tick();
        c_step = count;
        w_step = wrap;
        tick();
        w_next = wrap;
        key_n  = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        key_n  = 1'b1;
        dir_up = 1'b1;
        #2;
        checks++;
        if (count !== 4'd0 || wrap !== 1'b0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: count=%0d wrap=%0b pressed=%0b, expected 0/0/0", count, wrap, pressed);
        end
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (count !== 4'd0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: count=%0d pressed=%0b, expected 0/0", count, pressed);
        end
    endtask

    task automatic test_latency();
        logic [3:0] exp_c;
        do_reset();
        dir_up = 1'b1;
        key_n  = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 4'd0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge5: count=%0d pressed=%0b, expected 0/0", count, pressed);
        end
        tick();
        checks++;
        if (count !== 4'd1 || pressed !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL latency_edge6: count=%0d pressed=%0b wrap=%0b, expected 1/1/0", count, pressed, wrap);
        end
        repeat (14) tick();
        exp_c = RPT ? 4'd2 : 4'd1;   // repeat fires at edge 16 when enabled
        checks++;
        if (count !== exp_c || pressed !== 1'b1) begin
            errors++;
            $display("FAIL held_20: count=%0d pressed=%0b, expected %0d/1", count, pressed, exp_c);
        end
        key_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (pressed !== 1'b1) begin
            errors++;
            $display("FAIL release_edge5: pressed=%0b, expected 1", pressed);
        end
        tick();
        exp_c = RPT ? 4'd3 : 4'd1;
        checks++;
        if (pressed !== 1'b0 || count !== exp_c) begin
            errors++;
            $display("FAIL release_edge6: pressed=%0b count=%0d, expected 0/%0d", pressed, count, exp_c);
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] c;
        logic       w0, w1;
        do_reset();
        dir_up = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            press(c, w0, w1);
            checks++;
            if (i <= 10) begin
                if (c !== 4'(i) || w0 !== 1'b0) begin
                    errors++;
                    $display("FAIL up_press_%0d: count=%0d wrap=%0b, expected %0d/0", i, c, w0, i);
                end
            end else begin
                if (c !== 4'd0 || w0 !== 1'b1 || w1 !== 1'b0) begin
                    errors++;
                    $display("FAIL up_wrap: count=%0d wrap=%0b wrap_next=%0b, expected 0/1/0", c, w0, w1);
                end
            end
        end
    endtask

    task automatic test_wrap_down();
        logic [3:0] c;
        logic       w0, w1;
        do_reset();
        dir_up = 1'b0;
        press(c, w0, w1);
        checks++;
        if (c !== 4'd10 || w0 !== 1'b1 || w1 !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap: count=%0d wrap=%0b wrap_next=%0b, expected 10/1/0", c, w0, w1);
        end
        press(c, w0, w1);
        checks++;
        if (c !== 4'd9 || w0 !== 1'b0) begin
            errors++;
            $display("FAIL down_step: count=%0d wrap=%0b, expected 9/0", c, w0);
        end
    endtask

    task automatic test_dir_hold();
        logic [3:0] c;
        logic       w0, w1;
        do_reset();
        dir_up = 1'b1;
        key_n  = 1'b0;
        repeat (6) tick();
        dir_up = 1'b0;
        repeat (4) tick();
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL dir_toggle_held: count=%0d, expected 1", count);
        end
        key_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (count !== 4'd1 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL dir_release: count=%0d pressed=%0b, expected 1/0", count, pressed);
        end
        press(c, w0, w1);
        checks++;
        if (c !== 4'd0 || w0 !== 1'b0) begin
            errors++;
            $display("FAIL dir_next_step: count=%0d wrap=%0b, expected 0/0", c, w0);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        dir_up = 1'b1;
        key_n = 1'b0; repeat (3) tick();
        key_n = 1'b1; repeat (2) tick();
        key_n = 1'b0; repeat (3) tick();
        key_n = 1'b1; tick();
        key_n = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 4'd0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL bounce_pre: count=%0d pressed=%0b, expected 0/0", count, pressed);
        end
        tick();
        checks++;
        if (count !== 4'd1 || pressed !== 1'b1) begin
            errors++;
            $display("FAIL bounce_step: count=%0d pressed=%0b, expected 1/1", count, pressed);
        end
        key_n = 1'b1;
        repeat (8) tick();
        checks++;
        if (count !== 4'd1 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL bounce_single: count=%0d pressed=%0b, expected 1/0", count, pressed);
        end
    endtask

    task automatic test_hold();
        logic [3:0] exp_c;
        do_reset();
        dir_up = 1'b1;
        key_n  = 1'b0;
        repeat (6) tick();
        for (int k = 1; k <= 30; k++) begin
            tick();
            exp_c = (RPT && k >= 10) ? 4'(2 + (k - 10) / 5) : 4'd1;
            checks++;
            if (count !== exp_c) begin
                errors++;
                $display("FAIL hold_plus_%0d: count=%0d, expected %0d", k, count, exp_c);
            end
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        do_reset();
        dir_up = 1'b1;
        key_n  = 1'b0;
        repeat (6) tick();
        checks++;
        if (count !== 4'd1) begin
            errors++;
            $display("FAIL pre_async: count=%0d, expected 1", count);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== 4'd0 || pressed !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: count=%0d pressed=%0b wrap=%0b, expected 0/0/0", count, pressed, wrap);
        end
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (count !== 4'd0 || pressed !== 1'b0) begin
            errors++;
            $display("FAIL held_thru_reset_pre: count=%0d pressed=%0b, expected 0/0", count, pressed);
        end
        tick();
        checks++;
        if (count !== 4'd1 || pressed !== 1'b1) begin
            errors++;
            $display("FAIL held_thru_reset_step: count=%0d pressed=%0b, expected 1/1", count, pressed);
        end
        key_n = 1'b1;
        repeat (6) tick();
        checks++;
        if (pressed !== 1'b0 || count !== 4'd1) begin
            errors++;
            $display("FAIL held_thru_reset_rel: count=%0d pressed=%0b, expected 1/0", count, pressed);
        end
    endtask

    initial begin
        rst    = 1'b1;
        key_n  = 1'b1;
        dir_up = 1'b1;
        test_reset();
        test_latency();
        test_wrap_up();
        test_wrap_down();
        test_dir_hold();
        test_bounce();
        test_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
